// File: rtl/ym_dac_rx.sv
// Receiver for the YM2151 -> YM3012 serial DAC stream: decodes 13-bit float frames
// into signed 16-bit left/right samples, counts short frames and watches the p1 clock.
`timescale 1ns/1ps
module ym_dac_rx #(
   parameter int TIMEOUT_W = 8,
   parameter int ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ym_p1,
   input  logic             ym_so,
   input  logic             ym_sh1,
   input  logic             ym_sh2,
   output logic [15:0]      left,
   output logic [15:0]      right,
   output logic [12:0]      left_raw,
   output logic [12:0]      right_raw,
   output logic             left_valid,
   output logic             right_valid,
   output logic [ERR_W-1:0] err_cnt,
   output logic             p1_alive
);

   localparam logic [TIMEOUT_W-1:0] WD_MAX     = {TIMEOUT_W{1'b1}};
   localparam logic [ERR_W-1:0]     ERR_MAX    = {ERR_W{1'b1}};
   localparam logic [4:0]           BIT_MAX    = 5'd31;
   localparam logic [4:0]           FRAME_BITS = 5'd13;

   // Mantissa is offset binary; exponent 0 means silence, otherwise shift by e-1.
   function automatic logic [15:0] conv(input logic [12:0] f);
      logic [2:0]  e;
      logic [15:0] s;
      e = f[12:10];
      s = {{6{~f[9]}}, ~f[9], f[8:0]};
      if (e == 3'd0) begin
         conv = 16'h0000;
      end else begin
         conv = s << (e - 3'd1);
      end
   endfunction

   logic p1_s1_r, p1_s2_r, p1_d_r;
   logic so_s1_r, so_s2_r;
   logic sh1_s1_r, sh1_s2_r, sh1_d_r;
   logic sh2_s1_r, sh2_s2_r, sh2_d_r;

   logic [12:0]          sr_r;
   logic [4:0]           bitcnt_r;
   logic [TIMEOUT_W-1:0] wd_r;

   logic                 p1_rise_s;
   logic                 sh1_fall_s;
   logic                 sh2_fall_s;
   logic                 sh_any_s;
   logic                 long_s;
   logic [4:0]           bitcnt_nxt_s;
   logic [1:0]           err_inc_s;
   logic [ERR_W+1:0]     err_sum_s;
   logic [ERR_W-1:0]     err_nxt_s;
   logic [TIMEOUT_W-1:0] wd_nxt_s;
   logic                 alive_nxt_s;

   // Two-flop synchronisers plus a third flop for edge detection on p1/sh1/sh2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_s1_r  <= 1'b0;
         p1_s2_r  <= 1'b0;
         p1_d_r   <= 1'b0;
         so_s1_r  <= 1'b0;
         so_s2_r  <= 1'b0;
         sh1_s1_r <= 1'b0;
         sh1_s2_r <= 1'b0;
         sh1_d_r  <= 1'b0;
         sh2_s1_r <= 1'b0;
         sh2_s2_r <= 1'b0;
         sh2_d_r  <= 1'b0;
      end else begin
         p1_s1_r  <= ym_p1;
         p1_s2_r  <= p1_s1_r;
         p1_d_r   <= p1_s2_r;
         so_s1_r  <= ym_so;
         so_s2_r  <= so_s1_r;
         sh1_s1_r <= ym_sh1;
         sh1_s2_r <= sh1_s1_r;
         sh1_d_r  <= sh1_s2_r;
         sh2_s1_r <= ym_sh2;
         sh2_s2_r <= sh2_s1_r;
         sh2_d_r  <= sh2_s2_r;
      end
   end

   assign p1_rise_s  = p1_s2_r & ~p1_d_r;
   assign sh1_fall_s = ~sh1_s2_r & sh1_d_r;
   assign sh2_fall_s = ~sh2_s2_r & sh2_d_r;
   assign sh_any_s   = sh1_fall_s | sh2_fall_s;
   assign long_s     = (bitcnt_r >= FRAME_BITS);

   // Bit counter: a rise coinciding with a frame end counts as the first bit of the next frame.
   always_comb begin
      bitcnt_nxt_s = bitcnt_r;
      if (p1_rise_s) begin
         if (sh_any_s) begin
            bitcnt_nxt_s = 5'd1;
         end else if (bitcnt_r == BIT_MAX) begin
            bitcnt_nxt_s = BIT_MAX;
         end else begin
            bitcnt_nxt_s = bitcnt_r + 5'd1;
         end
      end else if (sh_any_s || !p1_alive) begin
         bitcnt_nxt_s = 5'd0;
      end else begin
         bitcnt_nxt_s = bitcnt_r;
      end
   end

   // Short-frame error accumulation, one step per failing channel, saturating.
   always_comb begin
      err_inc_s = {1'b0, sh1_fall_s & ~long_s} + {1'b0, sh2_fall_s & ~long_s};
      err_sum_s = {2'b00, err_cnt} + {{ERR_W{1'b0}}, err_inc_s};
      if (err_sum_s > {2'b00, ERR_MAX}) begin
         err_nxt_s = ERR_MAX;
      end else begin
         err_nxt_s = err_sum_s[ERR_W-1:0];
      end
   end

   // Watchdog next state.
   always_comb begin
      wd_nxt_s    = wd_r;
      alive_nxt_s = p1_alive;
      if (p1_rise_s) begin
         wd_nxt_s    = {TIMEOUT_W{1'b0}};
         alive_nxt_s = 1'b1;
      end else if (wd_r == WD_MAX) begin
         wd_nxt_s    = WD_MAX;
         alive_nxt_s = 1'b0;
      end else begin
         wd_nxt_s    = wd_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
         alive_nxt_s = p1_alive;
      end
   end

   // Shift register, counters and watchdog state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_r     <= 13'h0000;
         bitcnt_r <= 5'd0;
         wd_r     <= {TIMEOUT_W{1'b0}};
         p1_alive <= 1'b0;
         err_cnt  <= {ERR_W{1'b0}};
      end else begin
         if (p1_rise_s) begin
            sr_r <= {so_s2_r, sr_r[12:1]};
         end else begin
            sr_r <= sr_r;
         end
         bitcnt_r <= bitcnt_nxt_s;
         wd_r     <= wd_nxt_s;
         p1_alive <= alive_nxt_s;
         err_cnt  <= err_nxt_s;
      end
   end

   // Left channel latch; sr here is the value before any same-cycle shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left       <= 16'h0000;
         left_raw   <= 13'h0000;
         left_valid <= 1'b0;
      end else if (sh1_fall_s && long_s) begin
         left       <= conv(sr_r);
         left_raw   <= sr_r;
         left_valid <= 1'b1;
      end else begin
         left_valid <= 1'b0;
      end
   end

   // Right channel latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         right       <= 16'h0000;
         right_raw   <= 13'h0000;
         right_valid <= 1'b0;
      end else if (sh2_fall_s && long_s) begin
         right       <= conv(sr_r);
         right_raw   <= sr_r;
         right_valid <= 1'b1;
      end else begin
         right_valid <= 1'b0;
      end
   end

endmodule
